// File: rtl/data_mem_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package data_mem_responder_pkg;

  // Request size encodings carried on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  // Responder FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned CntW = 4;

  // True for the reserved size or an access not aligned to its own size.
  function automatic logic access_err(logic [1:0] size, logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Byte lanes touched by an access of the given size, lane 0 at the base address.
  function automatic logic [3:0] size_lanes(logic [1:0] size);
    logic [3:0] lanes;
    case (size)
      SZ_BYTE: lanes = 4'b0001;
      SZ_HALF: lanes = 4'b0011;
      default: lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// DEPTH x 8 byte storage: four consecutive bytes readable from a base address,
// each writable through its own lane enable. Storage is never reset.
module dmem_byte_array #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] lane_addr [4];

  // Lane i addresses byte base+i; combinational little-endian gather.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      lane_addr[i]      = addr + ADDR_W'(i);
      rdata[8*i +: 8]   = mem[lane_addr[i]];
    end
  end

  // Per-lane synchronous byte writes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[lane_addr[i]] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for the MEM stage: accepts one request, waits
// WAIT_CYCLES, performs the access against the byte array and holds the
// response until the consumer takes it.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam bit              NoWait   = (WAIT_CYCLES == 0);
  localparam logic [CntW-1:0] WaitInit = CntW'(WAIT_CYCLES);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              do_access;
  logic              acc_we;
  logic [1:0]        acc_size;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic [3:0]        lanes;
  logic [3:0]        mem_we;
  logic [31:0]       mem_rdata;
  logic [31:0]       load_data;
  logic [31:0]       rsp_data;

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Pick the live request in IDLE (zero-wait access) or the latched one later,
  // then decode lanes, error and steered load data.
  always_comb begin
    acc_we    = we_q;
    acc_size  = size_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == StIdle) begin
      acc_we    = req_we;
      acc_size  = req_size;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    acc_err = access_err(acc_size, acc_addr[1:0]);
    lanes   = size_lanes(acc_size);

    do_access = 1'b0;
    if (!rst) begin
      if (state_q == StIdle) begin
        do_access = accept && NoWait;
      end else if (state_q == StWait) begin
        do_access = (cnt_q <= CntW'(1));
      end
    end

    mem_we    = (do_access && acc_we && !acc_err) ? lanes : 4'b0000;
    load_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) begin
        load_data[8*i +: 8] = mem_rdata[8*i +: 8];
      end
    end
    rsp_data = (acc_err || acc_we) ? 32'h0 : load_data;
  end

  // Request/response FSM with wait counter and registered response outputs.
  always_ff @(posedge clka) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= WaitInit;
            if (do_access) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rdata_q     <= rsp_data;
              err_q       <= acc_err;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CntW'(1);
          if (do_access) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rsp_data;
            err_q       <= acc_err;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  dmem_byte_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clka),
    .we    (mem_we),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

endmodule
